if_fetch_stage: RTL

- Instruction-fetch stage directly upstream of decode.
- Owns the PC and drives a variable-latency instruction-memory request/ack port.
- Produces the IF/ID pipeline register (valid, PC+4, instruction) consumed by Control, Registers, Sign_Extend and the RegDst mux.
- Accepts stall from the hazard unit, and flush/redirect from branch resolution.

---
 rtl/if_fetch_stage.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : if_fetch_stage                                                |
// | Purpose  : Instruction-fetch stage ahead of decode. Owns the PC, drives  |
// |            a variable-latency instruction-memory request/ack port and    |
// |            produces the IF/ID pipeline register (valid, PC+4, instr).    |
// |            Honours stall from the hazard unit and flush/redirect from    |
// |            branch resolution.                                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk_i         in   1   clock, rising edge                              |
// |   rst_i         in   1   asynchronous active-low reset                   |
// |   start_i       in   1   run enable, sampled only in IDLE                |
// |   stall_i       in   1   decode cannot accept; hold IF/ID                |
// |   flush_i       in   1   redirect; kill IF/ID and in-flight fetch        |
// |   target_i      in  32   redirect address, valid with flush_i            |
// |   imem_req_o    out  1   fetch request                                   |
// |   imem_addr_o   out 32   fetch address, stable until ack                 |
// |   imem_ack_i    in   1   data valid for the current request             |
// |   imem_data_i   in  32   fetched instruction                             |
// |   pc_o          out 32   current fetch PC                                |
// |   ifid_valid_o  out  1   IF/ID holds a real instruction                  |
// |   ifid_pc4_o    out 32   PC of the IF/ID instruction plus 4              |
// |   ifid_instr_o  out 32   IF/ID instruction                               |
// |   bubble_cnt_o  out 32   (IF_FETCH_PERF_EN only) saturating count of     |
// |                          running cycles with IF/ID invalid               |
// | Optional feature macro: IF_FETCH_PERF_EN                                 |
// +--------------------------------------------------------------------------+
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] redirect_q, redirect_d;

  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  // Wraps naturally modulo 2^32.
  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = {target_i[31:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    hold_pc4_d   = hold_pc4_q;
    hold_instr_d = hold_instr_q;
    redirect_d   = redirect_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (flush_i) begin
          ifid_valid_d = 1'b0;
          ifid_pc4_d   = 32'd0;
          ifid_instr_d = NOP_INSTR;
          hold_pc4_d   = 32'd0;
          hold_instr_d = NOP_INSTR;
          if (imem_ack_i) begin
            pc_d = target_aligned;
          end else begin
            // The request in flight must finish at its original address
            // before the redirect can take effect.
            redirect_d = target_aligned;
            state_d    = ST_DRAIN;
          end
        end else if (imem_ack_i) begin
          if (!stall_i) begin
            ifid_valid_d = 1'b1;
            ifid_pc4_d   = pc_plus4;
            ifid_instr_d = imem_data_i;
            pc_d         = pc_plus4;
          end else begin
            // Park the returned word; PC advances only when it is delivered.
            hold_pc4_d   = pc_plus4;
            hold_instr_d = imem_data_i;
            state_d      = ST_HOLD;
          end
        end else if (!stall_i) begin
          ifid_valid_d = 1'b0;
          ifid_instr_d = NOP_INSTR;
        end
      end

      ST_HOLD: begin
        if (flush_i) begin
          ifid_valid_d = 1'b0;
          ifid_pc4_d   = 32'd0;
          ifid_instr_d = NOP_INSTR;
          hold_pc4_d   = 32'd0;
          hold_instr_d = NOP_INSTR;
          pc_d         = target_aligned;
          state_d      = ST_FETCH;
        end else if (!stall_i) begin
          ifid_valid_d = 1'b1;
          ifid_pc4_d   = hold_pc4_q;
          ifid_instr_d = hold_instr_q;
          pc_d         = pc_plus4;
          state_d      = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        ifid_valid_d = 1'b0;
        ifid_pc4_d   = 32'd0;
        ifid_instr_d = NOP_INSTR;
        if (flush_i) begin
          // A newer redirect supersedes the pending one.
          hold_pc4_d   = 32'd0;
          hold_instr_d = NOP_INSTR;
          redirect_d   = target_aligned;
        end else if (imem_ack_i) begin
          pc_d    = redirect_q;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc4_q   <= 32'd0;
      ifid_instr_q <= NOP_INSTR;
      hold_pc4_q   <= 32'd0;
      hold_instr_q <= NOP_INSTR;
      redirect_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      hold_instr_q <= hold_instr_d;
      redirect_q   <= redirect_d;
    end
  end

  // Request is a pure function of the registered state, so it drops the
  // instant reset asserts. In DRAIN pc_q still holds the killed address.
  assign imem_req_o   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if ((state_q != ST_IDLE) && !ifid_valid_q && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= 32'd0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
`default_nettype wire
